// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with two combinational read ports, one
// synchronous write port, optional write-to-read bypass and a per-register
// pending-write scoreboard used by decode for RAW/WAW hazard detection.
module regfile_sb #(
  parameter int              XLEN       = 32,
  parameter int              NREG       = 32,
  parameter int              AW         = $clog2(NREG),
  parameter int              SP_INDEX   = 2,
  parameter logic [XLEN-1:0] SP_INIT    = XLEN'(32'h2ffc),
  parameter bit              BYPASS     = 1'b1,
  parameter bit              SCOREBOARD = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rs1_dout,
  output logic [XLEN-1:0] rs2_dout,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] rd_din,
  input  logic            write_enable,
  input  logic            alloc_en,
  input  logic [AW-1:0]   alloc_rd,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            alloc_busy,
  output logic            proto_err
);

  logic [XLEN-1:0] rf [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic            wr_ok;
  logic            al_ok;
  logic            fwd1;
  logic            fwd2;
  logic            err_alloc;
  logic            err_write;

  // Index 0 is hardwired: writes and allocations to it are dropped.
  assign wr_ok = write_enable && (rd != '0);
  assign al_ok = SCOREBOARD && alloc_en && (alloc_rd != '0);

  // Forwarding only when enabled and the reader targets a real register.
  assign fwd1 = BYPASS && wr_ok && (rd == rs1);
  assign fwd2 = BYPASS && wr_ok && (rd == rs2);

  // Combinational read ports with optional same-cycle forwarding.
  always_comb begin
    rs1_dout = '0;
    rs2_dout = '0;
    if (rs1 != '0) rs1_dout = fwd1 ? rd_din : rf[rs1];
    if (rs2 != '0) rs2_dout = fwd2 ? rd_din : rf[rs2];
  end

  // A forwarded value is already available, so it hides the pending bit.
  assign rs1_busy   = busy[rs1] & ~fwd1;
  assign rs2_busy   = busy[rs2] & ~fwd2;
  assign alloc_busy = busy[alloc_rd];

  // Allocating an index that is still pending is legal only if writeback
  // retires that same index in the same cycle. Writing an index that has no
  // outstanding producer means decode and writeback disagree.
  assign err_alloc = al_ok && busy[alloc_rd] && !(wr_ok && (rd == alloc_rd));
  assign err_write = SCOREBOARD && wr_ok && !busy[rd];

  // Next scoreboard state: writeback clears first, alloc then sets so a new
  // producer supersedes the retiring one on the same index.
  always_comb begin
    busy_nxt = busy;
    if (wr_ok) busy_nxt[rd] = 1'b0;
    if (al_ok) busy_nxt[alloc_rd] = 1'b1;
  end

  // Register storage: reset loads the stack pointer, otherwise writeback.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= (i == SP_INDEX) ? SP_INIT : '0;
      end
    end else if (wr_ok) begin
      rf[rd] <= rd_din;
    end
  end

  // Scoreboard bits; held at zero when tracking is disabled.
  always_ff @(posedge clk) begin
    if (reset || !SCOREBOARD) busy <= '0;
    else                      busy <= busy_nxt;
  end

  // Sticky protocol error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset)                       proto_err <= 1'b0;
    else if (err_alloc || err_write) proto_err <= 1'b1;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed bench for regfile_sb. Two instances share all
// inputs: one with bypass enabled, one with bypass disabled.
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic [AW-1:0]   rs1, rs2, rd, alloc_rd;
  logic [XLEN-1:0] rd_din;
  logic            write_enable, alloc_en;

  logic [XLEN-1:0] b_rs1_dout, b_rs2_dout, n_rs1_dout, n_rs2_dout;
  logic            b_rs1_busy, b_rs2_busy, b_alloc_busy, b_proto_err;
  logic            n_rs1_busy, n_rs2_busy, n_alloc_busy, n_proto_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_sb #(.BYPASS(1'b1)) u_byp (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2),
    .rs1_dout(b_rs1_dout), .rs2_dout(b_rs2_dout),
    .rd(rd), .rd_din(rd_din), .write_enable(write_enable),
    .alloc_en(alloc_en), .alloc_rd(alloc_rd),
    .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy),
    .alloc_busy(b_alloc_busy), .proto_err(b_proto_err)
  );

  regfile_sb #(.BYPASS(1'b0)) u_nob (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2),
    .rs1_dout(n_rs1_dout), .rs2_dout(n_rs2_dout),
    .rd(rd), .rd_din(rd_din), .write_enable(write_enable),
    .alloc_en(alloc_en), .alloc_rd(alloc_rd),
    .rs1_busy(n_rs1_busy), .rs2_busy(n_rs2_busy),
    .alloc_busy(n_alloc_busy), .proto_err(n_proto_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_enable = 1'b0;
    alloc_en     = 1'b0;
    rd           = '0;
    alloc_rd     = '0;
    rd_din       = '0;
    reset        = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    idle();
    rs1 = '0;
    rs2 = '0;
    #1;
    do_reset();

    // Reset contents
    rs1 = 5'd2; rs2 = 5'd5; #1;
    chk("rst_rs1_sp",  b_rs1_dout, 32'h2ffc);
    chk("rst_rs2_zero", b_rs2_dout, 32'h0);
    chk("rst_nob_sp",  n_rs1_dout, 32'h2ffc);
    chk("rst_busy1",   b_rs1_busy, 1'b0);
    chk("rst_busy2",   b_rs2_busy, 1'b0);
    chk("rst_abusy",   b_alloc_busy, 1'b0);
    chk("rst_err",     b_proto_err, 1'b0);

    // x0 write and alloc are dropped silently
    rs1 = 5'd0;
    write_enable = 1'b1; rd = 5'd0; rd_din = 32'hdead_beef;
    alloc_en = 1'b1; alloc_rd = 5'd0; #1;
    chk("x0_fwd_dout", b_rs1_dout, 32'h0);
    chk("x0_fwd_busy", b_rs1_busy, 1'b0);
    tick();
    idle(); #1;
    chk("x0_dout", b_rs1_dout, 32'h0);
    chk("x0_busy", b_rs1_busy, 1'b0);
    chk("x0_err",  b_proto_err, 1'b0);

    // RAW via scoreboard on index 7
    alloc_en = 1'b1; alloc_rd = 5'd7;
    tick();
    idle();
    rs1 = 5'd7; rs2 = 5'd7; alloc_rd = 5'd7; #1;
    chk("raw_busy_b",  b_rs1_busy, 1'b1);
    chk("raw_busy_n",  n_rs1_busy, 1'b1);
    chk("raw_busy2_b", b_rs2_busy, 1'b1);
    chk("waw_abusy",   b_alloc_busy, 1'b1);
    write_enable = 1'b1; rd = 5'd7; rd_din = 32'h1234; #1;
    chk("byp_dout",    b_rs1_dout, 32'h1234);
    chk("byp_busy",    b_rs1_busy, 1'b0);
    chk("byp_dout2",   b_rs2_dout, 32'h1234);
    chk("nob_dout_old", n_rs1_dout, 32'h0);
    chk("nob_busy_old", n_rs1_busy, 1'b1);
    tick();
    idle(); #1;
    chk("nob_dout_new", n_rs1_dout, 32'h1234);
    chk("nob_busy_new", n_rs1_busy, 1'b0);
    chk("byp_dout_new", b_rs1_dout, 32'h1234);
    chk("raw_err",      b_proto_err, 1'b0);

    // Same-cycle alloc and write on busy index 9
    alloc_en = 1'b1; alloc_rd = 5'd9;
    tick();
    alloc_en = 1'b1; alloc_rd = 5'd9;
    write_enable = 1'b1; rd = 5'd9; rd_din = 32'h5555_aaaa;
    tick();
    idle();
    rs1 = 5'd9; #1;
    chk("sc9_dout",  b_rs1_dout, 32'h5555_aaaa);
    chk("sc9_busy",  b_rs1_busy, 1'b1);
    chk("sc9_err_b", b_proto_err, 1'b0);
    chk("sc9_err_n", n_proto_err, 1'b0);

    // Alloc to a busy index raises a sticky error
    alloc_en = 1'b1; alloc_rd = 5'd4;
    tick();
    #1;
    chk("a4_no_err", b_proto_err, 1'b0);
    tick();
    idle(); #1;
    chk("a4_err", b_proto_err, 1'b1);
    tick();
    tick();
    chk("a4_sticky", b_proto_err, 1'b1);

    // After reset, writing a non-busy index is an error
    do_reset(); #1;
    chk("rst2_err", b_proto_err, 1'b0);
    write_enable = 1'b1; rd = 5'd3; rd_din = 32'h77;
    tick();
    idle();
    rs1 = 5'd3; #1;
    chk("w3_err",  b_proto_err, 1'b1);
    chk("w3_dout", n_rs1_dout, 32'h77);

    // Reset mid-operation discards allocations and wins over a write
    do_reset();
    alloc_en = 1'b1; alloc_rd = 5'd3;
    tick();
    alloc_en = 1'b1; alloc_rd = 5'd4;
    tick();
    idle();
    rs1 = 5'd3; rs2 = 5'd4; #1;
    chk("pre_busy3", b_rs1_busy, 1'b1);
    chk("pre_busy4", b_rs2_busy, 1'b1);
    chk("pre_err",   b_proto_err, 1'b0);
    reset = 1'b1; write_enable = 1'b1; rd = 5'd3; rd_din = 32'hffff_ffff;
    tick();
    idle(); #1;
    chk("mid_dout3", n_rs1_dout, 32'h0);
    chk("mid_dout4", b_rs2_dout, 32'h0);
    chk("mid_busy3", b_rs1_busy, 1'b0);
    chk("mid_busy4", b_rs2_busy, 1'b0);
    chk("mid_err",   b_proto_err, 1'b0);
    rs1 = 5'd2; #1;
    chk("mid_sp",    b_rs1_dout, 32'h2ffc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file for the pipelined CPU core. It provides two asynchronous read ports and one synchronous write port, with register 0 hardwired to zero and a configurable stack-pointer reset value. It adds optional write-to-read bypass and a per-register pending-write scoreboard. The decode stage uses the scoreboard to detect RAW hazards and stall; writeback drives the write port.

## Interface
- XLEN, 32: data width in bits.
- NREG, 32: number of registers; power of two, ≥ 4.
- AW, $clog2(NREG): register index width; derived, do not override.
- SP_INDEX, 2: index of the register loaded with SP_INIT on reset.
- SP_INIT, 32'h2ffc: stack-pointer reset value, XLEN bits.
- BYPASS, 1: 1 = a same-cycle write is forwarded to the read outputs; 0 = read returns the stored value.
- SCOREBOARD, 1: 1 = busy tracking enabled; 0 = busy bits held at 0 and alloc_en ignored.

Ports:
- clk  in  1  the single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- rs1  in  AW  read port 1 index.
- rs2  in  AW  read port 2 index.
- rs1_dout  out  XLEN  read port 1 data.
- rs2_dout  out  XLEN  read port 2 data.
- rd  in  AW  write index.
- rd_din  in  XLEN  write data.
- write_enable  in  1  writeback strobe; writes rd_din to rd and clears busy[rd].
- alloc_en  in  1  decode issued an instruction that will write alloc_rd; sets its busy bit.
- alloc_rd  in  AW  destination being allocated.
- rs1_busy  out  1  rs1 has a pending write not yet available.
- rs2_busy  out  1  rs2 has a pending write not yet available.
- alloc_busy  out  1  busy[alloc_rd]; decode must stall on WAW.
- proto_err  out  1  sticky protocol-error flag.

## Operation
- Storage: rf[0..NREG-1] of XLEN bits; busy[0..NREG-1] of 1 bit.
- Register 0 always reads 0 and is never busy. Writes and allocs to index 0 are dropped silently and are not errors.
- Read path is combinational: rsX_dout = (rsX==0) ? 0 : (BYPASS && write_enable && rd==rsX) ? rd_din : rf[rsX].
- rsX_busy = busy[rsX] & ~(BYPASS && write_enable && rd==rsX). With BYPASS=0 the forwarded value is not visible, so busy stays asserted until the next cycle.
- Write: on the edge with write_enable=1 and rd≠0, rf[rd] takes rd_din and busy[rd] takes 0.
- Alloc: on the edge with alloc_en=1, alloc_rd≠0 and SCOREBOARD=1, busy[alloc_rd] takes 1.
- Simultaneous write and alloc to the same index: alloc wins and busy stays 1, because the new producer supersedes the old one. The data write still happens.
- Protocol errors set proto_err, which stays set until reset:
  - alloc_en while busy[alloc_rd]=1, unless write_enable clears that same index in that cycle;
  - write_enable to a non-zero rd with busy[rd]=0 while SCOREBOARD=1.
- Reset: every rf entry becomes 0 except rf[SP_INDEX], which becomes SP_INIT. All busy bits and proto_err become 0. Reset overrides any write or alloc in the same cycle.

## Timing
- Read latency is 0 cycles. A write becomes visible through rf on the cycle after its edge, or in the same cycle through bypass.
- Busy set/clear takes effect at the edge; rsX_busy updates combinationally from the new state.
- Reset values: rs1_dout/rs2_dout = 0 for index 0, otherwise the reset contents (SP_INIT at SP_INDEX, 0 elsewhere). All busy outputs = 0. proto_err = 0.
- Reset asserted mid-operation discards every pending allocation. The next cycle starts from a clean state.
- With SCOREBOARD=0 the block behaves as a plain register file and is usable by the single-cycle core.

## Test plan
- Reset: pulse reset, then read rs1=2, rs2=5 -> 32'h2ffc and 0; all busy outputs 0; proto_err 0.
- x0: write_enable, rd=0, rd_din=32'hdead_beef, alloc_en with alloc_rd=0 -> rs1=0 reads 0, rs1_busy 0, proto_err 0.
- Scoreboard RAW: alloc_rd=7; next cycle rs1=7 -> rs1_busy=1. Write rd=7, rd_din=32'h1234 with BYPASS=1 -> that same cycle rs1_dout=32'h1234 and rs1_busy=0. With BYPASS=0 -> old value and busy=1 that cycle; 32'h1234 and busy=0 the next cycle.
- Same-cycle alloc and write on index 9 (busy[9]=1 beforehand) -> rf[9] updated, busy[9] stays 1, proto_err 0.
- Errors: alloc to busy index 4 -> proto_err=1 and it persists. After reset, a write to non-busy index 3 -> proto_err=1.
- Reset mid-op: allocate indices 3 and 4, then assert reset together with write_enable rd=3 -> rf[3]=0, both busy bits 0.
